alu_hs: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output; generation-2 datapath ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/alu_hs.sv | 123 ++++++++++++
 tb/tb_alu_hs.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: op encoding and control FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_SLT = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Latency: WIDTH cycles after start, then done is held until the next clock.
// No backpressure: the caller samples product while done is high.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     sum;

    // Upper half accumulates; lower half starts as the multiplier and shifts out LSB-first.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= CNT_W'(WIDTH);
            busy  <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                acc <= {sum, acc[WIDTH-1:1]};
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign done    = busy && (cnt == '0);
    assign product = acc;

endmodule

// File: rtl/alu_hs.sv
// Registered ALU with valid/ready on both sides; 8 ops including an iterative MUL.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: result and flags hold while out_ready=0; in_ready follows out_ready in DONE.
module alu_hs
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam int SHAMT_W = $clog2(WIDTH);

    alu_state_t         state;
    alu_op_t            op_e;
    logic               accept;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     sub_s;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   res_c;
    logic               carry_c;
    logic               ov_c;

    assign op_e      = alu_op_t'(op);
    assign in_ready  = !reset && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op_e == OP_MUL);
    assign shamt     = src_b[SHAMT_W-1:0];
    assign add_s     = {1'b0, src_a} + {1'b0, src_b};
    assign sub_s     = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (src_a),
        .b       (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // In BUSY the load path carries the multiplier result instead of the live inputs.
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ov_c    = 1'b0;
        if (state == BUSY) begin
            res_c   = mul_prod[WIDTH-1:0];
            carry_c = |mul_prod[2*WIDTH-1:WIDTH];
        end else begin
            case (op_e)
                OP_AND: res_c = src_a & src_b;
                OP_OR:  res_c = src_a | src_b;
                OP_ADD: begin
                    res_c   = add_s[WIDTH-1:0];
                    carry_c = add_s[WIDTH];
                    ov_c    = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                              (add_s[WIDTH-1] != src_a[WIDTH-1]);
                end
                OP_SUB: begin
                    res_c   = sub_s[WIDTH-1:0];
                    carry_c = sub_s[WIDTH];
                    ov_c    = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                              (sub_s[WIDTH-1] != src_a[WIDTH-1]);
                end
                OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                OP_SLL: res_c = src_a << shamt;
                OP_SRL: res_c = src_a >> shamt;
                default: res_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alu_out   <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
        end else begin
            if ((state == BUSY && mul_done) || (accept && op_e != OP_MUL)) begin
                state     <= DONE;
                out_valid <= 1'b1;
                alu_out   <= res_c;
                zero      <= (res_c == '0);
                negative  <= res_c[WIDTH-1];
                carry     <= carry_c;
                overflow  <= ov_c;
            end else if (mul_start) begin
                state     <= BUSY;
                out_valid <= 1'b0;
            end else if (state == DONE && out_ready) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = mul_busy;

endmodule

// File: tb/tb_alu_hs.sv
// Directed-vector bench for alu_hs at WIDTH=8.
module tb_alu_hs;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] src_a;
    logic [7:0] src_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_out;
    logic       zero;
    logic       carry;
    logic       overflow;
    logic       negative;

    int vectors = 0;
    int miscompares = 0;

    alu_hs #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until the ALU takes it (bounded).
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        while (!in_ready && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) check("issue_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [7:0] r, input logic z,
                             input logic c, input logic v, input logic n);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out"},   32'(alu_out),   32'(r));
        check({tag, "_zero"},  32'(zero),      32'(z));
        check({tag, "_carry"}, 32'(carry),     32'(c));
        check({tag, "_ovf"},   32'(overflow),  32'(v));
        check({tag, "_neg"},   32'(negative),  32'(n));
    endtask

    initial begin
        int cyc;
        int stale;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; src_a = 8'h00; src_b = 8'h00;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_out",   32'(alu_out),   32'd0);
        check("rst_flags",     32'({zero, carry, overflow, negative}), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // ADD wraps to zero; result visible one cycle after accept
        issue(OP_ADD, 8'hFF, 8'h01);
        check_res("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        pop();
        check("add_popped", 32'(out_valid), 32'd0);

        issue(OP_SUB, 8'h80, 8'h01);
        check_res("sub_80_01", 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0);
        pop();
        issue(OP_SUB, 8'h01, 8'h02);
        check_res("sub_01_02", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        pop();

        // MUL: count cycles from accept to out_valid, in_ready low meanwhile
        issue(OP_MUL, 8'h0F, 8'h11);
        src_a = 8'hAA; src_b = 8'h55;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            check("mul_busy_in_ready", 32'(in_ready), 32'd0);
            step();
            cyc++;
        end
        check("mul_latency", 32'(cyc), 32'd9);
        check_res("mul_0f_11", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        pop();

        issue(OP_MUL, 8'h10, 8'h10);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("mul2_latency", 32'(cyc), 32'd9);
        check_res("mul_10_10", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

        // Backpressure: held result, in_ready low, input noise ignored
        op = OP_OR; src_a = 8'h12; src_b = 8'h34; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", 32'({out_valid, alu_out, zero, carry}), 32'({1'b1, 8'h00, 1'b1, 1'b1}));
        end

        // Pop and accept in the same cycle, then back-to-back
        op = OP_AND; src_a = 8'hF0; src_b = 8'h3C; out_ready = 1'b1;
        #1;
        check("pa_in_ready", 32'(in_ready), 32'd1);
        step();
        check_res("and_f0_3c", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        op = OP_OR; src_a = 8'h0F; src_b = 8'hF0;
        step();
        in_valid = 1'b0;
        check_res("or_0f_f0", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        out_ready = 1'b0;
        check("b2b_drained", 32'(out_valid), 32'd0);

        // Reset in the middle of a multiply
        issue(OP_MUL, 8'h03, 8'h05);
        step(); step(); step();
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out",   32'(alu_out),   32'd0);
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_rel_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid) stale++;
        end
        check("no_stale_result", 32'(stale), 32'd0);

        issue(OP_SLT, 8'hFE, 8'h01);
        check_res("slt_fe_01", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        pop();
        issue(OP_SRL, 8'h80, 8'h0B);
        check_res("srl_80_0b", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        pop();
        issue(OP_SLL, 8'h01, 8'h00);
        check_res("sll_01_0", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        pop();
        issue(OP_SLL, 8'h81, 8'h09);
        check_res("sll_81_9", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        pop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
